sdram_req_sched: RTL and testbench



---
 rtl/sdram_req_sched_if.sv | 47 ++++
 rtl/sdram_req_sched.sv | 200 ++++++++++++++++++++
 tb/tb_sdram_req_sched.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_req_sched_if.sv
// Host-post and SDRAM-controller handshake bundle for sdram_req_sched.
// slave = scheduler view, master = surrounding host/controller view.
interface sdram_req_sched_if #(
   parameter int unsigned ADDR_W = 22
);
   localparam int unsigned LEN_W = 9;

   logic              host_wr_req;
   logic [ADDR_W-1:0] host_wr_addr;
   logic [LEN_W-1:0]  host_wr_len;
   logic              host_rd_req;
   logic [ADDR_W-1:0] host_rd_addr;
   logic [LEN_W-1:0]  host_rd_len;
   logic              host_wr_busy;
   logic              host_rd_busy;
   logic              host_wr_done;
   logic              host_rd_done;

   logic              sdram_init_done;
   logic              sdram_busy;
   logic              sdram_wr_ack;
   logic              sdram_rd_ack;
   logic              sdram_wr_req;
   logic              sdram_rd_req;
   logic [LEN_W-1:0]  sdwr_bytes;
   logic [LEN_W-1:0]  sdrd_bytes;
   logic [ADDR_W-1:0] sdram_addr;
   logic              sched_err;

   modport slave (
      input  host_wr_req, host_wr_addr, host_wr_len,
      input  host_rd_req, host_rd_addr, host_rd_len,
      output host_wr_busy, host_rd_busy, host_wr_done, host_rd_done,
      input  sdram_init_done, sdram_busy, sdram_wr_ack, sdram_rd_ack,
      output sdram_wr_req, sdram_rd_req, sdwr_bytes, sdrd_bytes, sdram_addr,
      output sched_err
   );

   modport master (
      output host_wr_req, host_wr_addr, host_wr_len,
      output host_rd_req, host_rd_addr, host_rd_len,
      input  host_wr_busy, host_rd_busy, host_wr_done, host_rd_done,
      output sdram_init_done, sdram_busy, sdram_wr_ack, sdram_rd_ack,
      input  sdram_wr_req, sdram_rd_req, sdwr_bytes, sdrd_bytes, sdram_addr,
      input  sched_err
   );
endinterface

// File: rtl/sdram_req_sched.sv
// One write slot and one read slot arbitrated onto the single-outstanding SDRAM request handshake.
// Optional watchdog: define SDRAM_SCHED_TIMEOUT_EN.
module sdram_req_sched #(
   parameter int unsigned ADDR_W      = 22,
   parameter logic [15:0] TIMEOUT_CYC = 16'd4000
) (
   input  logic             clk_100m,
   input  logic             rst_n,
   sdram_req_sched_if.slave bus
);
   localparam int unsigned LEN_W = 9;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  len;
   } slot_t;

   typedef enum logic [2:0] {
      S_WAIT_INIT,
      S_IDLE,
      S_REQ_WR,
      S_REQ_RD,
      S_XFER_WR,
      S_XFER_RD,
      S_RECOVER
   } state_t;

   state_t            state;
   slot_t             wr_slot;
   slot_t             rd_slot;
   logic              last_wr;
   logic              wr_req;
   logic              rd_req;
   logic              wr_done;
   logic              rd_done;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  wr_bytes;
   logic [LEN_W-1:0]  rd_bytes;

   logic              tmo_c;
   logic              wr_clear_c;
   logic              rd_clear_c;
   logic              grant_wr_c;

`ifdef SDRAM_SCHED_TIMEOUT_EN
   logic [15:0] cnt;
   logic        err;
   logic        in_txn_c;

   assign in_txn_c = (state == S_REQ_WR) || (state == S_REQ_RD) ||
                     (state == S_XFER_WR) || (state == S_XFER_RD);
   assign tmo_c    = in_txn_c && bus.sdram_init_done && (cnt == TIMEOUT_CYC - 16'd1);

   // Every request is entered from S_IDLE, so clearing there restarts the watchdog per burst.
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (state == S_IDLE) cnt <= '0;
         else if (in_txn_c)   cnt <= cnt + 16'd1;
         if (tmo_c) err <= 1'b1;
      end
   end

   assign bus.sched_err = err;
`else
   logic unused_tmo_c;

   assign unused_tmo_c  = ^TIMEOUT_CYC;
   assign tmo_c         = 1'b0;
   assign bus.sched_err = 1'b0;
`endif

   // Slot release: normal completion when ack falls in XFER, or watchdog expiry.
   always_comb begin
      wr_clear_c = 1'b0;
      rd_clear_c = 1'b0;
      if (bus.sdram_init_done) begin
         wr_clear_c = (state == S_XFER_WR && !bus.sdram_wr_ack) ||
                      (tmo_c && (state == S_REQ_WR || state == S_XFER_WR));
         rd_clear_c = (state == S_XFER_RD && !bus.sdram_rd_ack) ||
                      (tmo_c && (state == S_REQ_RD || state == S_XFER_RD));
      end
   end

   assign grant_wr_c = wr_slot.valid && (!rd_slot.valid || !last_wr);

   // A post arriving while its slot is still valid (including the clearing cycle) is dropped.
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         wr_slot <= '0;
         rd_slot <= '0;
      end else begin
         if (wr_clear_c)
            wr_slot.valid <= 1'b0;
         else if (bus.host_wr_req && !wr_slot.valid && bus.host_wr_len != '0)
            wr_slot <= {1'b1, bus.host_wr_addr, bus.host_wr_len};
         if (rd_clear_c)
            rd_slot.valid <= 1'b0;
         else if (bus.host_rd_req && !rd_slot.valid && bus.host_rd_len != '0)
            rd_slot <= {1'b1, bus.host_rd_addr, bus.host_rd_len};
      end
   end

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_WAIT_INIT;
         last_wr  <= 1'b0;
         wr_req   <= 1'b0;
         rd_req   <= 1'b0;
         wr_done  <= 1'b0;
         rd_done  <= 1'b0;
         addr     <= '0;
         wr_bytes <= '0;
         rd_bytes <= '0;
      end else begin
         wr_done <= wr_clear_c;
         rd_done <= rd_clear_c;
         if (!bus.sdram_init_done) begin
            // Controller lost init: abandon the handshake, keep the slots for later.
            state    <= S_WAIT_INIT;
            wr_req   <= 1'b0;
            rd_req   <= 1'b0;
            addr     <= '0;
            wr_bytes <= '0;
            rd_bytes <= '0;
         end else begin
            unique case (state)
               S_WAIT_INIT: state <= S_IDLE;
               S_IDLE: begin
                  if (bus.sdram_busy && (wr_slot.valid || rd_slot.valid)) begin
                     last_wr <= grant_wr_c;
                     if (grant_wr_c) begin
                        state    <= S_REQ_WR;
                        wr_req   <= 1'b1;
                        addr     <= wr_slot.addr;
                        wr_bytes <= wr_slot.len;
                     end else begin
                        state    <= S_REQ_RD;
                        rd_req   <= 1'b1;
                        addr     <= rd_slot.addr;
                        rd_bytes <= rd_slot.len;
                     end
                  end
               end
               S_REQ_WR: begin
                  if (wr_clear_c) begin
                     state    <= S_RECOVER;
                     wr_req   <= 1'b0;
                     addr     <= '0;
                     wr_bytes <= '0;
                  end else if (bus.sdram_wr_ack) begin
                     state  <= S_XFER_WR;
                     wr_req <= 1'b0;
                  end
               end
               S_REQ_RD: begin
                  if (rd_clear_c) begin
                     state    <= S_RECOVER;
                     rd_req   <= 1'b0;
                     addr     <= '0;
                     rd_bytes <= '0;
                  end else if (bus.sdram_rd_ack) begin
                     state  <= S_XFER_RD;
                     rd_req <= 1'b0;
                  end
               end
               S_XFER_WR: begin
                  if (wr_clear_c) begin
                     state    <= S_RECOVER;
                     addr     <= '0;
                     wr_bytes <= '0;
                  end
               end
               S_XFER_RD: begin
                  if (rd_clear_c) begin
                     state    <= S_RECOVER;
                     addr     <= '0;
                     rd_bytes <= '0;
                  end
               end
               S_RECOVER: if (bus.sdram_busy) state <= S_IDLE;
               default:   state <= S_WAIT_INIT;
            endcase
         end
      end
   end

   assign bus.host_wr_busy = wr_slot.valid;
   assign bus.host_rd_busy = rd_slot.valid;
   assign bus.host_wr_done = wr_done;
   assign bus.host_rd_done = rd_done;
   assign bus.sdram_wr_req = wr_req;
   assign bus.sdram_rd_req = rd_req;
   assign bus.sdram_addr   = addr;
   assign bus.sdwr_bytes   = wr_bytes;
   assign bus.sdrd_bytes   = rd_bytes;
endmodule

// File: tb/tb_sdram_req_sched.sv
// Directed + randomized bench for sdram_req_sched against a slot-level transaction model.
module tb_sdram_req_sched;
   localparam int unsigned ADDR_W = 22;
   localparam logic [15:0] TMO    = 16'd100;

   logic clk_100m = 1'b0;
   logic rst_n    = 1'b0;
   always #5 clk_100m = ~clk_100m;

   sdram_req_sched_if #(.ADDR_W(ADDR_W)) bus ();

   sdram_req_sched #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
      .clk_100m (clk_100m),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // Reference model: pending slot per direction and who was granted last.
   logic              mw_v, mr_v, m_last_wr;
   logic [ADDR_W-1:0] mw_a, mr_a;
   logic [8:0]        mw_l, mr_l;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_100m);
      #1;
      chk("one_req_only", 64'(bus.sdram_wr_req & bus.sdram_rd_req), 64'd0);
   endtask

   task automatic model_reset();
      mw_v = 1'b0; mr_v = 1'b0; m_last_wr = 1'b0;
      mw_a = '0; mr_a = '0; mw_l = '0; mr_l = '0;
   endtask

   task automatic post(input logic dw, input logic [ADDR_W-1:0] wa, input logic [8:0] wl,
                       input logic dr, input logic [ADDR_W-1:0] ra, input logic [8:0] rl);
      bus.host_wr_req = dw; bus.host_wr_addr = wa; bus.host_wr_len = wl;
      bus.host_rd_req = dr; bus.host_rd_addr = ra; bus.host_rd_len = rl;
      step();
      bus.host_wr_req = 1'b0; bus.host_rd_req = 1'b0;
      if (dw && !mw_v && wl != 9'd0) begin mw_v = 1'b1; mw_a = wa; mw_l = wl; end
      if (dr && !mr_v && rl != 9'd0) begin mr_v = 1'b1; mr_a = ra; mr_l = rl; end
      chk("wr_busy_after_post", 64'(bus.host_wr_busy), 64'(mw_v));
      chk("rd_busy_after_post", 64'(bus.host_rd_busy), 64'(mr_v));
   endtask

   // Act as the controller for one burst; the model decides which slot must be granted.
   task automatic serve(input int ack_len, input logic post_at_clear);
      logic              gw;
      logic [ADDR_W-1:0] ea;
      logic [8:0]        el;
      int                t;
      gw = mw_v && (!mr_v || !m_last_wr);
      ea = gw ? mw_a : mr_a;
      el = gw ? mw_l : mr_l;
      t  = 0;
      while (!(bus.sdram_wr_req || bus.sdram_rd_req) && t < 64) begin step(); t++; end
      chk("grant_seen", 64'(bus.sdram_wr_req | bus.sdram_rd_req), 64'd1);
      chk("grant_dir_wr", 64'(bus.sdram_wr_req), 64'(gw));
      chk("grant_addr", 64'(bus.sdram_addr), 64'(ea));
      chk("grant_wr_bytes", 64'(bus.sdwr_bytes), gw ? 64'(el) : 64'd0);
      chk("grant_rd_bytes", 64'(bus.sdrd_bytes), gw ? 64'd0 : 64'(el));
      m_last_wr = gw;
      bus.sdram_busy = 1'b0;
      if (gw) bus.sdram_wr_ack = 1'b1; else bus.sdram_rd_ack = 1'b1;
      step();
      chk("req_drop_after_ack", 64'(bus.sdram_wr_req | bus.sdram_rd_req), 64'd0);
      chk("xfer_addr_held", 64'(bus.sdram_addr), 64'(ea));
      for (int i = 1; i < ack_len; i++) step();
      bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0;
      if (post_at_clear) begin
         bus.host_wr_addr = ADDR_W'($urandom); bus.host_rd_addr = ADDR_W'($urandom);
         bus.host_wr_len = 9'd5; bus.host_rd_len = 9'd5;
         if (gw) bus.host_wr_req = 1'b1; else bus.host_rd_req = 1'b1;
      end
      step();
      bus.host_wr_req = 1'b0; bus.host_rd_req = 1'b0;
      chk("done_wr", 64'(bus.host_wr_done), 64'(gw));
      chk("done_rd", 64'(bus.host_rd_done), 64'(!gw));
      if (gw) mw_v = 1'b0; else mr_v = 1'b0;
      chk("busy_wr_after_done", 64'(bus.host_wr_busy), 64'(mw_v));
      chk("busy_rd_after_done", 64'(bus.host_rd_busy), 64'(mr_v));
      chk("addr_zero_after_done", 64'(bus.sdram_addr), 64'd0);
      bus.sdram_busy = 1'b1;
      step();
      chk("done_one_cycle", 64'(bus.host_wr_done | bus.host_rd_done), 64'd0);
      chk("clear_cycle_post_dropped_wr", 64'(bus.host_wr_busy), 64'(mw_v));
      chk("clear_cycle_post_dropped_rd", 64'(bus.host_rd_busy), 64'(mr_v));
   endtask

   function automatic logic [63:0] all_outs();
      return {bus.host_wr_busy, bus.host_rd_busy, bus.host_wr_done, bus.host_rd_done,
              bus.sdram_wr_req, bus.sdram_rd_req, bus.sched_err,
              bus.sdwr_bytes, bus.sdrd_bytes, bus.sdram_addr};
   endfunction

   initial begin
      logic [ADDR_W-1:0] a0, a1;
      logic [8:0]        l0, l1;
      int                t;
      logic              dw, dr;

      bus.host_wr_req = 1'b0; bus.host_wr_addr = '0; bus.host_wr_len = '0;
      bus.host_rd_req = 1'b0; bus.host_rd_addr = '0; bus.host_rd_len = '0;
      bus.sdram_init_done = 1'b0; bus.sdram_busy = 1'b0;
      bus.sdram_wr_ack = 1'b0; bus.sdram_rd_ack = 1'b0;
      model_reset();

      // Reset state
      #12;
      chk("reset_outputs", all_outs(), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_reset_outputs", all_outs(), 64'd0);

      // Posting before init completes: slot fills, no request
      a0 = ADDR_W'($urandom); l0 = 9'($urandom_range(1, 511));
      post(1'b1, a0, l0, 1'b0, '0, 9'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("no_req_before_init", 64'(bus.sdram_wr_req | bus.sdram_rd_req), 64'd0);
      end
      bus.sdram_init_done = 1'b1; bus.sdram_busy = 1'b1;
      serve(2, 1'b0);

      // Basic write: request two cycles after the post edge
      post(1'b1, 22'h01234, 9'd256, 1'b0, '0, 9'd0);
      chk("basic_req_not_yet", 64'(bus.sdram_wr_req), 64'd0);
      step();
      chk("basic_req_high", 64'(bus.sdram_wr_req), 64'd1);
      chk("basic_addr", 64'(bus.sdram_addr), 64'h01234);
      chk("basic_bytes", 64'(bus.sdwr_bytes), 64'd256);
      serve(3, 1'b0);

      // Refresh in progress holds off a pending read
      bus.sdram_busy = 1'b0;
      a0 = ADDR_W'($urandom); l0 = 9'($urandom_range(1, 511));
      post(1'b0, '0, 9'd0, 1'b1, a0, l0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("no_req_during_refresh", 64'(bus.sdram_rd_req), 64'd0);
      end
      bus.sdram_busy = 1'b1;
      step();
      chk("rd_req_after_refresh", 64'(bus.sdram_rd_req), 64'd1);
      serve(2, 1'b0);

      // Simultaneous posts, twice: alternation starts from write
      for (int k = 0; k < 2; k++) begin
         a0 = ADDR_W'($urandom); l0 = 9'($urandom_range(1, 511));
         a1 = ADDR_W'($urandom); l1 = 9'($urandom_range(1, 511));
         post(1'b1, a0, l0, 1'b1, a1, l1);
         chk("contend_first_is_wr", 64'(mw_v && !m_last_wr), 64'd1);
         serve(2, 1'b0);
         serve(1, 1'b0);
      end

      // Second write while slot valid and a zero-length read are both dropped
      a0 = ADDR_W'($urandom); l0 = 9'($urandom_range(1, 511));
      post(1'b1, a0, l0, 1'b0, '0, 9'd0);
      post(1'b1, ADDR_W'($urandom), 9'd77, 1'b1, ADDR_W'($urandom), 9'd0);
      chk("len0_read_dropped", 64'(bus.host_rd_busy), 64'd0);
      serve(3, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("no_extra_req", 64'(bus.sdram_wr_req | bus.sdram_rd_req), 64'd0);
         chk("no_extra_done", 64'(bus.host_wr_done | bus.host_rd_done), 64'd0);
      end

      // Init lost during a request: req dropped, slot retained, reissued later
      a0 = ADDR_W'($urandom); l0 = 9'($urandom_range(1, 511));
      post(1'b1, a0, l0, 1'b0, '0, 9'd0);
      step();
      chk("req_before_init_loss", 64'(bus.sdram_wr_req), 64'd1);
      bus.sdram_init_done = 1'b0;
      step();
      chk("req_dropped_init_loss", 64'(bus.sdram_wr_req), 64'd0);
      chk("slot_kept_init_loss", 64'(bus.host_wr_busy), 64'd1);
      chk("addr_zero_init_loss", 64'(bus.sdram_addr), 64'd0);
      step();
      bus.sdram_init_done = 1'b1;
      serve(1, 1'b0);

      // Randomized posting rounds, drained by the model's arbitration order
      for (int r = 0; r < 20; r++) begin
         bus.sdram_busy = 1'b0;
         for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
            dw = 1'($urandom); dr = 1'($urandom);
            l0 = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
            l1 = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
            post(dw, ADDR_W'($urandom), l0, dr, ADDR_W'($urandom), l1);
         end
         bus.sdram_busy = 1'b1;
         while (mw_v || mr_v) serve(int'($urandom_range(1, 4)), 1'($urandom));
      end

      // Reset during a read transfer
      a0 = ADDR_W'($urandom); l0 = 9'($urandom_range(1, 511));
      post(1'b0, '0, 9'd0, 1'b1, a0, l0);
      step();
      chk("rd_req_before_reset", 64'(bus.sdram_rd_req), 64'd1);
      bus.sdram_rd_ack = 1'b1;
      step();
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outputs", all_outs(), 64'd0);
      bus.sdram_rd_ack = 1'b0;
      bus.sdram_init_done = 1'b0;
      model_reset();
      step();
      rst_n = 1'b1;
      step();
      chk("no_done_after_reset", 64'(bus.host_rd_done), 64'd0);
      chk("slot_empty_after_reset", 64'(bus.host_rd_busy), 64'd0);
      a0 = ADDR_W'($urandom); l0 = 9'($urandom_range(1, 511));
      post(1'b1, a0, l0, 1'b0, '0, 9'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("no_req_until_reinit", 64'(bus.sdram_wr_req | bus.sdram_rd_req), 64'd0);
      end
      bus.sdram_init_done = 1'b1;
      serve(2, 1'b0);

`ifdef SDRAM_SCHED_TIMEOUT_EN
      // Ack never returned: watchdog completes the burst and flags the error
      a0 = ADDR_W'($urandom); l0 = 9'($urandom_range(1, 511));
      post(1'b1, a0, l0, 1'b0, '0, 9'd0);
      t = 0;
      while (!bus.sdram_wr_req && t < 16) begin step(); t++; end
      chk("tmo_req_seen", 64'(bus.sdram_wr_req), 64'd1);
      t = 0;
      while (!bus.host_wr_done && t < 300) begin step(); t++; end
      chk("tmo_done_cycle", 64'(t), 64'(TMO));
      chk("tmo_err_set", 64'(bus.sched_err), 64'd1);
      chk("tmo_slot_cleared", 64'(bus.host_wr_busy), 64'd0);
      mw_v = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("tmo_err_sticky", 64'(bus.sched_err), 64'd1);
`else
      chk("err_stays_zero", 64'(bus.sched_err), 64'd0);
      t = 0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
